// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage: bus widths, hazard-unit
// hold codes, reset/bubble constants, fetch state encoding and a word-align
// helper used when forming redirect targets.
// ---------------------------------------------------------------------------
package if_stage_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int HOLD_W = 3;

   // Hold codes are ordered by pipeline depth; any code at or above
   // HOLD_CODE_IF freezes the IF/ID register.
   localparam logic [HOLD_W-1:0] HOLD_CODE_ID = 3'd3;
   localparam logic [HOLD_W-1:0] HOLD_CODE_IF = HOLD_CODE_ID - 3'd1;

   localparam logic [DATA_W-1:0] DEF_INSTR_NOP  = 32'h0000_0013;
   localparam logic [ADDR_W-1:0] DEF_RESET_ADDR = 32'h0000_0000;

   typedef enum logic {
      S_FETCH = 1'b0,
      S_DROP  = 1'b1
   } fetch_state_e;

   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if_id.sv
// ---------------------------------------------------------------------------
// if_id
// IF/ID pipeline register. Flush overrides hold; when neither is active the
// register loads whatever the fetch stage presents (fresh data, the skid
// buffer, or a bubble).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   flush        load the bubble instruction (address is kept)
//   hold_n       0 = keep current contents
//   instr, addr  next instruction / address offered by the fetch stage
//   instr_q      registered instruction to decode
//   addr_q       registered instruction address to decode
// ---------------------------------------------------------------------------
module if_id
   import if_stage_pkg::*;
#(
   parameter logic [DATA_W-1:0] NOP_INSTR = DEF_INSTR_NOP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              hold_n,
   input  logic [DATA_W-1:0] instr,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] instr_q,
   output logic [ADDR_W-1:0] addr_q
);

   // Flush wins over hold so a redirect always kills the wrong-path slot,
   // even while the decoder is stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_q <= NOP_INSTR;
         addr_q  <= '0;
      end else if (flush) begin
         instr_q <= NOP_INSTR;
      end else if (hold_n) begin
         instr_q <= instr;
         addr_q  <= addr;
      end
   end

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Owns the PC, drives a req/ack instruction memory
// port, catches a returning instruction in a one-entry skid buffer while the
// IF/ID register is held, and discards wrong-path responses after a redirect.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   hold_code      pipeline hold code from the hazard unit
//   jmp_flag_i     redirect pulse (taken branch / jump)
//   jmp_addr_i     redirect target (low two bits ignored)
//   instr_req_o    instruction memory request
//   instr_addr_o   request address, word aligned
//   instr_ack_i    memory response valid this cycle
//   instr_data_i   fetched instruction
//   instr_o        IF/ID instruction to decode
//   addr_instr_o   IF/ID instruction address to decode
// ---------------------------------------------------------------------------
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_ADDR = DEF_RESET_ADDR,
   parameter logic [DATA_W-1:0] INSTR_NOP  = DEF_INSTR_NOP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [HOLD_W-1:0] hold_code,
   input  logic              jmp_flag_i,
   input  logic [ADDR_W-1:0] jmp_addr_i,
   output logic              instr_req_o,
   output logic [ADDR_W-1:0] instr_addr_o,
   input  logic              instr_ack_i,
   input  logic [DATA_W-1:0] instr_data_i,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] addr_instr_o
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] redir_q, redir_d;
   logic              buf_valid_q, buf_valid_d;
   logic [DATA_W-1:0] buf_instr_q, buf_instr_d;
   logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;

   logic              hold_if;
   logic              accept;
   logic [ADDR_W-1:0] jmp_target;
   logic [DATA_W-1:0] ifid_instr;
   logic [ADDR_W-1:0] ifid_addr;

   assign hold_if      = (hold_code >= HOLD_CODE_IF);
   assign jmp_target   = word_align(jmp_addr_i);
   assign instr_addr_o = pc_q;
   assign accept       = instr_req_o & instr_ack_i;

   // The request is gated by rst_n so nothing is asked of memory while reset
   // is asserted. In S_DROP the wrong-path request must stay open until its
   // ack; in S_FETCH a full skid buffer throttles further fetches.
   always_comb begin
      instr_req_o = 1'b0;
      if (rst_n) begin
         if (state_q == S_DROP) begin
            instr_req_o = 1'b1;
         end else begin
            instr_req_o = ~buf_valid_q;
         end
      end
   end

   // Next-state logic for PC, redirect target, skid buffer and fetch state.
   // A jump seen while a request is still waiting cannot retarget the bus,
   // so the target is parked in redir_q and applied when the stale ack lands.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      redir_d     = redir_q;
      buf_valid_d = buf_valid_q;
      buf_instr_d = buf_instr_q;
      buf_addr_d  = buf_addr_q;

      case (state_q)
         S_FETCH: begin
            if (jmp_flag_i) begin
               buf_valid_d = 1'b0;
               if (instr_req_o && !instr_ack_i) begin
                  state_d = S_DROP;
                  redir_d = jmp_target;
               end else begin
                  pc_d = jmp_target;
               end
            end else begin
               if (accept) begin
                  pc_d = pc_q + 32'd4;
                  if (hold_if) begin
                     buf_valid_d = 1'b1;
                     buf_instr_d = instr_data_i;
                     buf_addr_d  = pc_q;
                  end
               end
               if (buf_valid_q && !hold_if) begin
                  buf_valid_d = 1'b0;
               end
            end
         end
         S_DROP: begin
            if (jmp_flag_i) begin
               redir_d = jmp_target;
            end
            if (instr_ack_i) begin
               state_d = S_FETCH;
               pc_d    = jmp_flag_i ? jmp_target : redir_q;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_ADDR;
         redir_q     <= '0;
         buf_valid_q <= 1'b0;
         buf_instr_q <= '0;
         buf_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         redir_q     <= redir_d;
         buf_valid_q <= buf_valid_d;
         buf_instr_q <= buf_instr_d;
         buf_addr_q  <= buf_addr_d;
      end
   end

   // Source selection for the IF/ID register when it is neither flushed nor
   // held: the skid buffer drains first, then fresh on-path data, otherwise a
   // bubble with the address left untouched.
   always_comb begin
      ifid_instr = INSTR_NOP;
      ifid_addr  = addr_instr_o;
      if (buf_valid_q) begin
         ifid_instr = buf_instr_q;
         ifid_addr  = buf_addr_q;
      end else if (accept && (state_q == S_FETCH)) begin
         ifid_instr = instr_data_i;
         ifid_addr  = pc_q;
      end
   end

   if_id #(
      .NOP_INSTR (INSTR_NOP)
   ) u_if_id (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (jmp_flag_i),
      .hold_n  (~hold_if),
      .instr   (ifid_instr),
      .addr    (ifid_addr),
      .instr_q (instr_o),
      .addr_q  (addr_instr_o)
   );

endmodule
